// File: rtl/div_ctrl.sv
// Multi-cycle 32-bit restoring divider (DIV/DIVU) with EX-stage sequencing control.
// Latency: 33 cycles accept->ready (2 for divide-by-zero); ready_o is a one-cycle pulse.
// Backpressure: stallreq_o holds the pipeline from accept until the ready cycle; annul_i aborts.
module div_ctrl #(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic                signed_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic                annul_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o,
    output logic                busy_o,
    output logic                stallreq_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIVZERO,
        S_ON,
        S_END
    } state_t;

    localparam int              CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    // {partial remainder, quotient}; bit 2*DATA_W is headroom for the shifted remainder
    logic [2*DATA_W:0]   acc_q, acc_d;
    logic [DATA_W-1:0]   dvs_q, dvs_d;
    logic                neg_quo_q, neg_quo_d;
    logic                neg_rem_q, neg_rem_d;
    logic [2*DATA_W-1:0] result_q, result_d;

    logic                accept;
    logic [DATA_W-1:0]   abs1, abs2;
    logic [DATA_W+1:0]   partial;
    logic [DATA_W+1:0]   diff;
    logic [2*DATA_W:0]   step_res;
    logic [DATA_W-1:0]   quo_raw, rem_raw;
    logic [2*DATA_W-1:0] fixed_res;

    assign accept = (state_q == S_IDLE) && start_i && !annul_i;

    // Operand magnitudes: the iterative core only ever divides unsigned values
    assign abs1 = (signed_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    assign abs2 = (signed_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

    // One restoring step: shift in the next dividend bit, subtract if it fits
    assign partial  = acc_q[2*DATA_W:DATA_W-1];
    assign diff     = partial - {2'b00, dvs_q};
    assign step_res = diff[DATA_W+1] ? {acc_q[2*DATA_W-1:0], 1'b0}
                                     : {diff[DATA_W:0], acc_q[DATA_W-2:0], 1'b1};

    // Sign correction applied when the result is presented
    assign quo_raw   = acc_q[DATA_W-1:0];
    assign rem_raw   = acc_q[2*DATA_W-1:DATA_W];
    assign fixed_res = {(neg_rem_q ? -rem_raw : rem_raw),
                        (neg_quo_q ? -quo_raw : quo_raw)};

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    dvs_d     = abs2;
                    acc_d     = {{(DATA_W+1){1'b0}}, abs1};
                    neg_quo_d = signed_i && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                    neg_rem_d = signed_i && opdata1_i[DATA_W-1];
                    cnt_d     = '0;
                    state_d   = (opdata2_i == '0) ? S_DIVZERO : S_ON;
                end
            end
            S_DIVZERO: begin
                if (annul_i) begin
                    state_d = S_IDLE;
                end else begin
                    // Zero the datapath so the END correction yields an all-zero result
                    acc_d     = '0;
                    neg_quo_d = 1'b0;
                    neg_rem_d = 1'b0;
                    state_d   = S_END;
                end
            end
            S_ON: begin
                if (annul_i) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = step_res;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_END;
                    end
                end
            end
            S_END: begin
                result_d = fixed_res;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
        end
    end

    // The corrected value is shown during the ready cycle and held afterwards
    assign ready_o    = (state_q == S_END);
    assign busy_o     = (state_q != S_IDLE);
    assign result_o   = ready_o ? fixed_res : result_q;
    assign stallreq_o = !rst && (accept ||
                        (((state_q == S_DIVZERO) || (state_q == S_ON)) && !annul_i));

endmodule

// File: tb/tb_div_ctrl.sv
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        signed_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        busy_o;
    logic        stallreq_o;

    always #5 clk = ~clk;

    div_ctrl #(.DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .signed_i   (signed_i),
        .opdata1_i  (opdata1_i),
        .opdata2_i  (opdata2_i),
        .annul_i    (annul_i),
        .result_o   (result_o),
        .ready_o    (ready_o),
        .busy_o     (busy_o),
        .stallreq_o (stallreq_o)
    );

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t        vecs[10];
    logic [63:0] sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          ready_cyc = -1;
    logic [63:0] last_exp = 64'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Scoreboard: every ready pulse must match the oldest outstanding expected result
    always @(negedge clk) begin
        if (ready_o === 1'b1) begin
            ready_cyc = cyc;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready at cycle %0d: got result %h expected no pulse", cyc, result_o);
            end else begin
                check("result", result_o, sb_q.pop_front());
            end
        end
    end

    // Reference model built from the language's truncating division
    function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'h0) return 64'h0;
        if (sgn) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // Entered just after a rising edge (cycle 0); returns one cycle after ready
    task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int lat, input logic annul_end);
        start_i   = 1'b1;
        signed_i  = sgn;
        opdata1_i = a;
        opdata2_i = b;
        sb_q.push_back(exp);
        for (int c = 0; c <= lat; c++) begin
            @(negedge clk);
            check("stallreq", stallreq_o, (c < lat));
            check("ready", ready_o, (c == lat));
            check("busy", busy_o, (c > 0));
            if (c == lat) start_i = 1'b0;
            @(posedge clk);
            #1;
            if (c == 0) begin
                opdata1_i = $urandom;
                opdata2_i = $urandom;
                signed_i  = ~sgn;
            end
            if (c + 1 == lat) annul_i = annul_end;
        end
        annul_i  = 1'b0;
        last_exp = exp;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          prev_ready;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;

        rst       = 1'b1;
        start_i   = 1'b0;
        signed_i  = 1'b0;
        opdata1_i = 32'h0;
        opdata2_i = 32'h0;
        annul_i   = 1'b0;

        vecs[0] = '{1'b0, 32'd100,        32'd7,        {32'd2,        32'd14},        33};
        vecs[1] = '{1'b1, 32'hFFFFFFF9,   32'h2,        {32'hFFFFFFFF, 32'hFFFFFFFD},  33};
        vecs[2] = '{1'b0, 32'hFFFFFFF9,   32'h2,        {32'h1,        32'h7FFFFFFC},  33};
        vecs[3] = '{1'b1, 32'd5,          32'd0,        64'h0,                         2};
        vecs[4] = '{1'b1, 32'h80000000,   32'hFFFFFFFF, {32'h0,        32'h80000000},  33};
        vecs[5] = '{1'b0, 32'hFFFFFFFF,   32'h1,        {32'h0,        32'hFFFFFFFF},  33};
        vecs[6] = '{1'b1, 32'd7,          32'hFFFFFFFE, {32'h1,        32'hFFFFFFFD},  33};
        vecs[7] = '{1'b0, 32'd0,          32'd0,        64'h0,                         2};
        vecs[8] = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, {32'hFFFFFFFE, 32'h0000000E},  33};
        vecs[9] = '{1'b0, 32'hDEADBEEF,   32'h10,       {32'hF,        32'h0DEADBEE},  33};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_result", result_o, 64'h0);
        check("rst_ready", ready_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_stallreq", stallreq_o, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Table vectors issued back to back: each start follows the previous ready cycle
        prev_ready = -1;
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, 1'b0);
            check("hold_result", result_o, vecs[i].exp);
            if (i > 0) check("b2b_gap", 64'(ready_cyc - prev_ready), 64'(vecs[i].lat + 1));
            prev_ready = ready_cyc;
        end

        // Random operands against the reference model
        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            rs = 1'($urandom_range(0, 1));
            if (ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'h3;
            run_op(rs, ra, rb, model(rs, ra, rb), (rb == 32'h0) ? 2 : 33, 1'b0);
        end

        // annul_i during END does not suppress the result
        run_op(1'b0, 32'd50, 32'd5, {32'd0, 32'd10}, 33, 1'b1);
        check("annul_end_hold", result_o, {32'd0, 32'd10});

        // annul_i in IDLE blocks the accept
        start_i   = 1'b1;
        annul_i   = 1'b1;
        opdata1_i = 32'd9;
        opdata2_i = 32'd3;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("idle_annul_stall", stallreq_o, 1'b0);
            check("idle_annul_busy", busy_o, 1'b0);
            @(posedge clk);
            #1;
        end
        start_i = 1'b0;
        annul_i = 1'b0;
        @(posedge clk);
        #1;

        // annul_i in cycle 10 of an op: no result, new start in cycle 12 finishes in cycle 45
        start_i   = 1'b1;
        signed_i  = 1'b0;
        opdata1_i = 32'd1000;
        opdata2_i = 32'd9;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("pre_annul_stall", stallreq_o, 1'b1);
            @(posedge clk);
            #1;
        end
        annul_i = 1'b1;
        start_i = 1'b0;
        @(negedge clk);
        check("annul_stall_drop", stallreq_o, 1'b0);
        check("annul_busy", busy_o, 1'b1);
        @(posedge clk);
        #1;
        annul_i = 1'b0;
        @(negedge clk);
        check("annul_idle", busy_o, 1'b0);
        check("annul_no_ready", ready_o, 1'b0);
        check("annul_result_kept", result_o, last_exp);
        @(posedge clk);
        #1;
        run_op(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 1'b0);

        // Reset in cycle 20 of an op clears everything, including result_o
        start_i   = 1'b1;
        signed_i  = 1'b1;
        opdata1_i = 32'd1000;
        opdata2_i = 32'd3;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
        end
        rst     = 1'b1;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("mid_rst_result", result_o, 64'h0);
        check("mid_rst_ready", ready_o, 1'b0);
        check("mid_rst_busy", busy_o, 1'b0);
        check("mid_rst_stallreq", stallreq_o, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_result", result_o, 64'h0);

        check("sb_empty", 64'(sb_q.size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
